// File: rtl/mc_ctrl_pkg.sv
// Shared encodings, RV32I opcodes, FSM state codes and decode record for the
// multi-cycle control sequencer.
package mc_ctrl_pkg;

    localparam logic [1:0] RF_WSEL_ALU = 2'd0;
    localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
    localparam logic [1:0] RF_WSEL_EXT = 2'd2;
    localparam logic [1:0] RF_WSEL_RDO = 2'd3;

    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_LOAD   = 3'd1,
        CL_STORE  = 3'd2,
        CL_BRANCH = 3'd3,
        CL_JUMP   = 3'd4,
        CL_LUI    = 3'd5
    } ins_class_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       asel;
        logic       bsel;
        logic [2:0] sext_op;
        logic [1:0] rf_wsel;
        logic [1:0] npc_op;
        ins_class_e cls;
        logic       illegal;
    } dec_t;

    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] alu_for_branch(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b001:  op = ALU_BNE;
            3'b100:  op = ALU_BLT;
            3'b101:  op = ALU_BGE;
            3'b110:  op = ALU_BLTU;
            3'b111:  op = ALU_BGEU;
            default: op = ALU_BEQ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory handshakes plus datapath control bundle between the
// sequencer (master) and the memories/datapath (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst;
    logic             imem_req;
    logic             imem_ack;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             br_flag;
    logic [3:0]       alu_op;
    logic             alu_asel;
    logic             alu_bsel;
    logic [2:0]       sext_op;
    logic [1:0]       rf_wsel;
    logic             rf_we;
    logic [1:0]       npc_op;
    logic             pc_we;
    logic             fault;
    logic [CNT_W-1:0] instret;

    modport master (
        input  inst, imem_ack, dmem_ack, br_flag,
        output imem_req, ir_we, dmem_req, dmem_we, alu_op, alu_asel, alu_bsel,
               sext_op, rf_wsel, rf_we, npc_op, pc_we, fault, instret
    );

    modport slave (
        output inst, imem_ack, dmem_ack, br_flag,
        input  imem_req, ir_we, dmem_req, dmem_we, alu_op, alu_asel, alu_bsel,
               sext_op, rf_wsel, rf_we, npc_op, pc_we, fault, instret
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational RV32I decoder: registered opcode/funct fields to datapath
// selects, instruction class and an illegal-encoding flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output dec_t       o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.alu_op  = ALU_ADD;
        o_dec.sext_op = SEXT_I;
        o_dec.rf_wsel = RF_WSEL_ALU;
        o_dec.npc_op  = NPC_PC4;
        o_dec.cls     = CL_ALU;
        case (i_opcode)
            OPC_LUI: begin
                o_dec.cls     = CL_LUI;
                o_dec.sext_op = SEXT_U;
                o_dec.bsel    = 1'b1;
                o_dec.rf_wsel = RF_WSEL_EXT;
            end
            OPC_AUIPC: begin
                o_dec.sext_op = SEXT_U;
                o_dec.asel    = 1'b1;
                o_dec.bsel    = 1'b1;
            end
            OPC_JAL: begin
                o_dec.cls     = CL_JUMP;
                o_dec.sext_op = SEXT_J;
                o_dec.asel    = 1'b1;
                o_dec.bsel    = 1'b1;
                o_dec.rf_wsel = RF_WSEL_PC4;
                o_dec.npc_op  = NPC_JAL;
            end
            OPC_JALR: begin
                o_dec.cls     = CL_JUMP;
                o_dec.bsel    = 1'b1;
                o_dec.rf_wsel = RF_WSEL_PC4;
                o_dec.npc_op  = NPC_JALR;
                o_dec.illegal = (i_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                o_dec.cls     = CL_BRANCH;
                o_dec.sext_op = SEXT_B;
                o_dec.npc_op  = NPC_BR;
                o_dec.alu_op  = alu_for_branch(i_funct3);
                o_dec.illegal = (i_funct3 inside {3'b010, 3'b011});
            end
            OPC_LOAD: begin
                o_dec.cls     = CL_LOAD;
                o_dec.bsel    = 1'b1;
                o_dec.rf_wsel = RF_WSEL_RDO;
                o_dec.illegal = (i_funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                o_dec.cls     = CL_STORE;
                o_dec.sext_op = SEXT_S;
                o_dec.bsel    = 1'b1;
                o_dec.illegal = (i_funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                // Only the shift-right immediate uses funct7[5] (SRAI); ADDI has no subtract form.
                o_dec.bsel    = 1'b1;
                o_dec.alu_op  = alu_from_funct(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
                o_dec.illegal = ((i_funct3 == 3'b001) && (i_funct7 != 7'b0000000)) ||
                                ((i_funct3 == 3'b101) && ((i_funct7 & 7'b1011111) != 7'b0000000));
            end
            OPC_OP: begin
                o_dec.alu_op  = alu_from_funct(i_funct3, i_funct7[5]);
                o_dec.illegal = !((i_funct7 == 7'b0000000) ||
                                  ((i_funct7 == 7'b0100000) &&
                                   ((i_funct3 == 3'b000) || (i_funct3 == 3'b101))));
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ack timeout,
// sticky fault and retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mc_ctrl_if.master bus
);

    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic              r_fault;
    logic [CNT_W-1:0]  r_instret;
    dec_t              w_dec;

    logic              w_imem_req;
    logic              w_ir_we;
    logic              w_dmem_req;
    logic              w_dmem_we;
    logic [3:0]        w_alu_op;
    logic              w_alu_asel;
    logic              w_alu_bsel;
    logic [2:0]        w_sext_op;
    logic [1:0]        w_rf_wsel;
    logic              w_rf_we;
    logic [1:0]        w_npc_op;
    logic              w_pc_we;

    mc_ctrl_decode u_decode (
        .i_opcode (r_opcode),
        .i_funct3 (r_funct3),
        .i_funct7 (r_funct7),
        .o_dec    (w_dec)
    );

    // The wait counter defaults to zero, so every state entry starts a fresh count.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = '0;
        case (r_state)
            ST_IDLE:   w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ack)
                    w_state_next = ST_DECODE;
                else if (r_wait == WAIT_LAST)
                    w_state_next = ST_TRAP;
                else
                    w_wait_next = r_wait + WAIT_W'(1);
            end
            ST_DECODE: w_state_next = w_dec.illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (w_dec.cls)
                    CL_BRANCH:         w_state_next = ST_FETCH;
                    CL_LOAD, CL_STORE: w_state_next = ST_MEM;
                    default:           w_state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack)
                    w_state_next = (w_dec.cls == CL_STORE) ? ST_FETCH : ST_WB;
                else if (r_wait == WAIT_LAST)
                    w_state_next = ST_TRAP;
                else
                    w_wait_next = r_wait + WAIT_W'(1);
            end
            ST_WB:     w_state_next = ST_FETCH;
            ST_TRAP:   w_state_next = ST_TRAP;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_fault   <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_ir_we) begin
                r_opcode <= bus.inst[6:0];
                r_funct3 <= bus.inst[14:12];
                r_funct7 <= bus.inst[31:25];
            end
            if (w_state_next == ST_TRAP)
                r_fault <= 1'b1;
            if (w_pc_we)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    // ALU selects and immediate format stay stable from EXEC through write-back.
    always_comb begin
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_alu_op   = '0;
        w_alu_asel = 1'b0;
        w_alu_bsel = 1'b0;
        w_sext_op  = '0;
        w_rf_wsel  = '0;
        w_rf_we    = 1'b0;
        w_npc_op   = NPC_PC4;
        w_pc_we    = 1'b0;
        if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
            w_alu_op   = w_dec.alu_op;
            w_alu_asel = w_dec.asel;
            w_alu_bsel = w_dec.bsel;
        end
        if (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
            w_sext_op = w_dec.sext_op;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_we    = bus.imem_ack;
            end
            ST_EXEC: begin
                if (w_dec.cls == CL_BRANCH) begin
                    w_npc_op = NPC_BR;
                    w_pc_we  = 1'b1;
                end
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_dec.cls == CL_STORE);
                w_pc_we    = (w_dec.cls == CL_STORE) && bus.dmem_ack;
            end
            ST_WB: begin
                w_rf_wsel = w_dec.rf_wsel;
                w_rf_we   = 1'b1;
                w_npc_op  = w_dec.npc_op;
                w_pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imem_req = w_imem_req;
    assign bus.ir_we    = w_ir_we;
    assign bus.dmem_req = w_dmem_req;
    assign bus.dmem_we  = w_dmem_we;
    assign bus.alu_op   = w_alu_op;
    assign bus.alu_asel = w_alu_asel;
    assign bus.alu_bsel = w_alu_bsel;
    assign bus.sext_op  = w_sext_op;
    assign bus.rf_wsel  = w_rf_wsel;
    assign bus.rf_we    = w_rf_we;
    assign bus.npc_op   = w_npc_op;
    assign bus.pc_we    = w_pc_we;
    assign bus.fault    = r_fault;
    assign bus.instret  = r_instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed per-cycle vector table for mc_ctrl plus hand-written sequences for
// timeouts, illegal opcode and asynchronous reset mid-access.
module tb_mc_ctrl;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0080A283;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_JAL = 32'h010000EF;
    localparam logic [31:0] I_SW  = 32'h0020A423;
    localparam logic [31:0] I_ILL = 32'hFFFFFFFF;

    typedef struct packed {
        logic        imem_req;
        logic        ir_we;
        logic        dmem_req;
        logic        dmem_we;
        logic [3:0]  alu_op;
        logic        asel;
        logic        bsel;
        logic [2:0]  sext_op;
        logic [1:0]  rf_wsel;
        logic        rf_we;
        logic [1:0]  npc_op;
        logic        pc_we;
        logic        fault;
        logic [31:0] instret;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        ia;
        logic        da;
        logic        br;
        outs_t       exp;
    } vec_t;

    logic  clk;
    logic  rst_n;
    int    n_tests;
    int    n_fail;
    vec_t  vecs[$];
    outs_t o;
    outs_t zero_o;
    int    n;

    mc_ctrl_if #(.CNT_W(32)) ifc ();

    mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(int ireq, int irwe, int dreq, int dwe, int alu, int as, int bs,
                                 int sx, int ws, int rwe, int np, int pw, int f, int ir);
        outs_t r;
        r.imem_req = (ireq != 0);
        r.ir_we    = (irwe != 0);
        r.dmem_req = (dreq != 0);
        r.dmem_we  = (dwe != 0);
        r.alu_op   = 4'(alu);
        r.asel     = (as != 0);
        r.bsel     = (bs != 0);
        r.sext_op  = 3'(sx);
        r.rf_wsel  = 2'(ws);
        r.rf_we    = (rwe != 0);
        r.npc_op   = 2'(np);
        r.pc_we    = (pw != 0);
        r.fault    = (f != 0);
        r.instret  = 32'(ir);
        return r;
    endfunction

    function automatic outs_t sample();
        outs_t r;
        r.imem_req = ifc.imem_req;
        r.ir_we    = ifc.ir_we;
        r.dmem_req = ifc.dmem_req;
        r.dmem_we  = ifc.dmem_we;
        r.alu_op   = ifc.alu_op;
        r.asel     = ifc.alu_asel;
        r.bsel     = ifc.alu_bsel;
        r.sext_op  = ifc.sext_op;
        r.rf_wsel  = ifc.rf_wsel;
        r.rf_we    = ifc.rf_we;
        r.npc_op   = ifc.npc_op;
        r.pc_we    = ifc.pc_we;
        r.fault    = ifc.fault;
        r.instret  = ifc.instret;
        return r;
    endfunction

    task automatic add_vec(input string name, input logic [31:0] inst, input logic ia,
                           input logic da, input logic br, input outs_t exp);
        vec_t v;
        v.name = name; v.inst = inst; v.ia = ia; v.da = da; v.br = br; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("[TB] %s ok (%h)", name, got);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("[TB] %s ok (%0d)", name, got);
        end
    endtask

    // Called at a falling edge: drive inputs, sample mid-low-phase, advance one clock.
    task automatic cyc(input logic [31:0] inst_v, input logic ia, input logic da,
                       input logic br, output outs_t r);
        ifc.inst     = inst_v;
        ifc.imem_ack = ia;
        ifc.dmem_ack = da;
        ifc.br_flag  = br;
        #1;
        r = sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        ifc.inst     = '0;
        ifc.imem_ack = 1'b0;
        ifc.dmem_ack = 1'b0;
        ifc.br_flag  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        zero_o  = '0;

        // add x3,x1,x2 with zero-wait fetch; stray acks/br_flag must be ignored
        add_vec("add idle",    32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        add_vec("add fetch",   I_ADD, 1'b1, 1'b0, 1'b0, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        add_vec("add decode",  32'h0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        add_vec("add exec",    32'h0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        add_vec("add wb",      32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,0,0, 0,1,0,1, 0,0));
        // lw x5,8(x1) with two wait cycles on the data bus
        add_vec("lw fetch",    I_LW,  1'b1, 1'b0, 1'b0, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,1));
        add_vec("lw decode",   32'h0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1));
        add_vec("lw exec",     32'h0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0, 0,0,1,0, 0,0,0,0, 0,1));
        add_vec("lw mem w1",   32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,1,0, 0,0,1,0, 0,0,0,0, 0,1));
        add_vec("lw mem w2",   32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,1,0, 0,0,1,0, 0,0,0,0, 0,1));
        add_vec("lw mem ack",  32'h0, 1'b0, 1'b1, 1'b0, mk(0,0,1,0, 0,0,1,0, 0,0,0,0, 0,1));
        add_vec("lw wb",       32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,1,0, 3,1,0,1, 0,1));
        // beq taken: PC updated from EXEC, straight back to FETCH
        add_vec("beq fetch",   I_BEQ, 1'b1, 1'b0, 1'b0, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,2));
        add_vec("beq decode",  32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,0,2, 0,0,0,0, 0,2));
        add_vec("beq exec",    32'h0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0, 10,0,0,2, 0,0,1,1, 0,2));
        // jal x1,16
        add_vec("jal fetch",   I_JAL, 1'b1, 1'b0, 1'b0, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,3));
        add_vec("jal decode",  32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,0,4, 0,0,0,0, 0,3));
        add_vec("jal exec",    32'h0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0, 0,1,1,4, 0,0,0,0, 0,3));
        add_vec("jal wb",      32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,1,1,4, 1,1,2,1, 0,3));
        // sw with zero-wait data ack: PC update in the MEM cycle
        add_vec("sw fetch",    I_SW,  1'b1, 1'b0, 1'b0, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,4));
        add_vec("sw decode",   32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 0,4));
        add_vec("sw exec",     32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0, 0,0,1,1, 0,0,0,0, 0,4));
        add_vec("sw mem ack",  32'h0, 1'b0, 1'b1, 1'b0, mk(0,0,1,1, 0,0,1,1, 0,0,0,1, 0,4));
        add_vec("next fetch",  32'h0, 1'b0, 1'b0, 1'b0, mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,5));

        rst_n        = 1'b0;
        ifc.inst     = I_ADD;
        ifc.imem_ack = 1'b1;
        ifc.dmem_ack = 1'b1;
        ifc.br_flag  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", sample(), zero_o);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].inst, vecs[i].ia, vecs[i].da, vecs[i].br, o);
            check(vecs[i].name, o, vecs[i].exp);
        end

        // sw interrupted by reset while waiting in MEM
        cyc(I_SW, 1'b1, 1'b0, 1'b0, o);
        check("sw2 fetch", o, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,5));
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        ifc.dmem_ack = 1'b0;
        #1;
        check("sw2 mem wait", sample(), mk(0,0,1,1, 0,0,1,1, 0,0,0,0, 0,5));
        #2;
        rst_n = 1'b0;
        #1;
        check("sw2 async reset", sample(), zero_o);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch timeout: request for exactly 4 cycles, then sticky fault
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        check("to idle", o, zero_o);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
            if (!o.imem_req) break;
            n++;
        end
        check_int("fetch timeout req cycles", n, 4);
        check("fetch timeout trap", o, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0));
        cyc(I_ADD, 1'b1, 1'b1, 1'b1, o);
        check("trap ignores acks", o, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0));
        rst_n = 1'b0;
        #1;
        check("trap cleared by reset", sample(), zero_o);
        @(negedge clk);
        rst_n = 1'b1;

        // ack on the 4th request cycle is accepted, no fault
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(I_ADD, 1'b1, 1'b0, 1'b0, o);
        check("ack on last cycle", o, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        check("ack4 decode no fault", o, zero_o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        check("ack4 wb", o, mk(0,0,0,0, 0,0,0,0, 0,1,0,1, 0,0));

        // data-side timeout on a load that is never acknowledged
        cyc(I_LW, 1'b1, 1'b0, 1'b0, o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
            if (!o.dmem_req) break;
            n++;
        end
        check_int("mem timeout req cycles", n, 4);
        check("mem timeout trap", o, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,1));

        // illegal instruction traps after DECODE
        do_reset();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(I_ILL, 1'b1, 1'b0, 1'b0, o);
        check("illegal fetch", o, mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, o);
        check("illegal trap", o, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0));
        cyc(I_ADD, 1'b1, 1'b1, 1'b1, o);
        check("illegal trap sticky", o, mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
